// File: rtl/dmem_ctrl.sv
// dmem_ctrl: MEM-stage data memory controller. It takes valid/ready requests and answers with a one-cycle response pulse.
// Define DMEM_MISALIGN_EN to run misaligned word/halfword accesses as two word beats; when it is undefined they are rejected as errors.
module dmem_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int DEPTH_WORDS = 512
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [2:0]        i_req_func3,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err
);
  // state | meaning
  // IDLE  | ready, request accepted here
  // ACC0  | beat 0: word A read/written
  // ACC1  | beat 1: word A+1 read/written (split only)
  // RESP  | response registered on exit
  localparam int IW = ADDR_W - 2;
  localparam int DW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [IW:0] DEPTH_L = (IW+1)'(DEPTH_WORDS);

  typedef enum logic [1:0] {ST_IDLE, ST_ACC0, ST_ACC1, ST_RESP} state_t;
  state_t state_q, state_d;

  logic          we_q, err_q;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic [DW-1:0] widx_q;
  logic [31:0]   wdata_q;
  logic          rsp_valid_q, rsp_err_q;
  logic [31:0]   rsp_rdata_q;
  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [31:0]   lo_q;
`ifdef DMEM_MISALIGN_EN
  logic [31:0]   hi_q;
  logic          split_q;
`endif

  logic          accept, f3_bad, st_bad, split_req, split_bad, err_req;
  logic [1:0]    req_off;
  logic [IW-1:0] req_widx;

  assign accept    = i_req_valid && (state_q == ST_IDLE);
  assign req_off   = i_req_addr[1:0];
  assign req_widx  = i_req_addr[ADDR_W-1:2];
  assign f3_bad    = (i_req_func3 == 3'b011) || (i_req_func3[2:1] == 2'b11);
  assign st_bad    = i_req_we && i_req_func3[2];
  assign split_req = ((i_req_func3[1:0] == 2'b10) && (req_off != 2'b00)) ||
                     ((i_req_func3[1:0] == 2'b01) && (req_off == 2'b11));
`ifdef DMEM_MISALIGN_EN
  logic [IW:0] req_widx_inc;
  assign req_widx_inc = {1'b0, req_widx} + {{IW{1'b0}}, 1'b1};
  assign split_bad    = split_req && (req_widx_inc >= DEPTH_L);
`else
  assign split_bad    = split_req;
`endif
  assign err_req = f3_bad || st_bad || ({1'b0, req_widx} >= DEPTH_L) || split_bad;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      widx_q  <= '0;
      wdata_q <= '0;
`ifdef DMEM_MISALIGN_EN
      split_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= i_req_we;
        err_q   <= err_req;
        f3_q    <= i_req_func3;
        off_q   <= req_off;
        widx_q  <= req_widx[DW-1:0];
        wdata_q <= i_req_wdata;
`ifdef DMEM_MISALIGN_EN
        split_q <= split_req;
`endif
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = err_req ? ST_RESP : ST_ACC0;
`ifdef DMEM_MISALIGN_EN
      ST_ACC0: state_d = split_q ? ST_ACC1 : ST_RESP;
      ST_ACC1: state_d = ST_RESP;
`else
      ST_ACC0: state_d = ST_RESP;
`endif
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  logic [3:0]    base_be, mem_be;
  logic [31:0]   mem_wd, ld_shift, ld_ext;
  logic [DW-1:0] mem_idx;
  logic          mem_we;

  always_comb begin
    case (f3_q[1:0])
      2'b00:   base_be = 4'b0001;
      2'b01:   base_be = 4'b0011;
      default: base_be = 4'b1111;
    endcase
  end

  always_comb begin
    mem_idx = widx_q;
    mem_be  = base_be << off_q;
    mem_wd  = wdata_q << {off_q, 3'b000};
    mem_we  = we_q && (state_q == ST_ACC0);
`ifdef DMEM_MISALIGN_EN
    if (state_q == ST_ACC1) begin
      // Beat 1 carries the bytes that spilled past the top of word A.
      mem_idx = widx_q + DW'(1);
      mem_be  = base_be >> (3'd4 - {1'b0, off_q});
      mem_wd  = wdata_q >> (6'd32 - {1'b0, off_q, 3'b000});
      mem_we  = we_q;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem_q[mem_idx][8*b +: 8] <= mem_wd[8*b +: 8];
      end
    end
    if (state_q == ST_ACC0) lo_q <= mem_q[mem_idx];
`ifdef DMEM_MISALIGN_EN
    if (state_q == ST_ACC1) hi_q <= mem_q[mem_idx];
`endif
  end

`ifdef DMEM_MISALIGN_EN
  assign ld_shift = 32'({hi_q, lo_q} >> {off_q, 3'b000});
`else
  assign ld_shift = lo_q >> {off_q, 3'b000};
`endif

  always_comb begin
    case (f3_q[1:0])
      2'b00:   ld_ext = {{24{ld_shift[7]  & ~f3_q[2]}}, ld_shift[7:0]};
      2'b01:   ld_ext = {{16{ld_shift[15] & ~f3_q[2]}}, ld_shift[15:0]};
      default: ld_ext = ld_shift;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= (state_q == ST_RESP);
      rsp_err_q   <= (state_q == ST_RESP) && err_q;
      rsp_rdata_q <= ((state_q == ST_RESP) && !err_q && !we_q) ? ld_ext : 32'h0;
    end
  end

  assign o_req_ready = (state_q == ST_IDLE);
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_rsp_rdata = rsp_rdata_q;
endmodule
